stack_pop_sequencer: RTL and testbench

Multi-cycle pop sequencer that performs the return side of the stack protocol for RET and RTI. On a request it stalls the front end and reads the saved state back from the data stack: flags first for RTI, then the low 16-bit PC half, then the high half. It then reassembles the 32-bit PC, restores the flags and updates SP in a single commit cycle. It sits between decode and the memory stage and is the counterpart of the CALL/interrupt push sequencer.

---
 rtl/stack_pop_if.sv | 33 +++
 rtl/stack_pop_sequencer.sv | 133 +++++++++++++
 tb/tb_stack_pop_sequencer.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stack_pop_if.sv
// Request, stack-read and restore signals between decode/memory and the pop sequencer.
// The sequencer uses the slave side; decode and the stack memory use the master side.
interface stack_pop_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 11
);
    logic                start_ret;
    logic                start_rti;
    logic                flush;
    logic [ADDR_W-1:0]   sp_in;
    logic [DATA_W-1:0]   mem_rdata;
    logic                mem_rd;
    logic [ADDR_W-1:0]   mem_addr;
    logic                stall;
    logic                pc_load;
    logic [2*DATA_W-1:0] pc_out;
    logic                flags_load;
    logic [DATA_W-1:0]   flags_out;
    logic                sp_we;
    logic [ADDR_W-1:0]   sp_out;

    modport master (
        output start_ret, start_rti, flush, sp_in, mem_rdata,
        input  mem_rd, mem_addr, stall, pc_load, pc_out,
               flags_load, flags_out, sp_we, sp_out
    );

    modport slave (
        input  start_ret, start_rti, flush, sp_in, mem_rdata,
        output mem_rd, mem_addr, stall, pc_load, pc_out,
               flags_load, flags_out, sp_we, sp_out
    );
endinterface

// File: rtl/stack_pop_sequencer.sv
// Return-side stack sequencer for RET/RTI: pops flags (RTI), PC low and PC high,
// then restores PC, flags and SP in one commit cycle.
module stack_pop_sequencer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    stack_pop_if.slave    bus
);

    typedef enum logic [2:0] {
        IDLE,
        POP_F,
        POP_LO,
        POP_HI,
        COMMIT
    } state_t;

    state_t              state_reg;
    logic                kind_rti_reg;
    logic [ADDR_W-1:0]   base_reg;
    logic [DATA_W-1:0]   flags_reg;
    logic [DATA_W-1:0]   lo_reg;
    logic [2*DATA_W-1:0] pc_hold_reg;
    logic [DATA_W-1:0]   flags_hold_reg;
    logic [ADDR_W-1:0]   sp_hold_reg;

    logic                commit_fire;
    logic [ADDR_W-1:0]   off_w;
    logic [ADDR_W-1:0]   sp_commit;
    logic [2*DATA_W-1:0] pc_commit;

    // RTI frames carry one extra word (flags) below the PC halves.
    assign off_w       = ADDR_W'(kind_rti_reg);
    assign sp_commit   = base_reg + (kind_rti_reg ? ADDR_W'(3) : ADDR_W'(2));
    assign pc_commit   = {bus.mem_rdata, lo_reg};
    assign commit_fire = (state_reg == COMMIT) && !bus.flush;

    always_comb begin
        bus.mem_rd   = 1'b0;
        bus.mem_addr = '0;
        case (state_reg)
            POP_F: begin
                bus.mem_rd   = 1'b1;
                bus.mem_addr = base_reg + ADDR_W'(1);
            end
            POP_LO: begin
                bus.mem_rd   = 1'b1;
                bus.mem_addr = base_reg + off_w + ADDR_W'(1);
            end
            POP_HI: begin
                bus.mem_rd   = 1'b1;
                bus.mem_addr = base_reg + off_w + ADDR_W'(2);
            end
            default: begin
                bus.mem_rd   = 1'b0;
                bus.mem_addr = '0;
            end
        endcase
    end

    // Stall drops in COMMIT so fetch restarts from pc_out on the following cycle.
    assign bus.stall = (state_reg != COMMIT) &&
                       (bus.start_ret || bus.start_rti || (state_reg != IDLE));

    // The high PC half arrives during COMMIT, so restored values bypass the hold registers.
    assign bus.pc_load    = commit_fire;
    assign bus.sp_we      = commit_fire;
    assign bus.flags_load = commit_fire && kind_rti_reg;
    assign bus.pc_out     = commit_fire ? pc_commit : pc_hold_reg;
    assign bus.sp_out     = commit_fire ? sp_commit : sp_hold_reg;
    assign bus.flags_out  = (commit_fire && kind_rti_reg) ? flags_reg : flags_hold_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            kind_rti_reg   <= 1'b0;
            base_reg       <= '0;
            flags_reg      <= '0;
            lo_reg         <= '0;
            pc_hold_reg    <= '0;
            flags_hold_reg <= '0;
            sp_hold_reg    <= '0;
        end else begin
            if (commit_fire) begin
                pc_hold_reg <= pc_commit;
                sp_hold_reg <= sp_commit;
                if (kind_rti_reg) begin
                    flags_hold_reg <= flags_reg;
                end
            end

            if (bus.flush) begin
                state_reg <= IDLE;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (bus.start_rti) begin
                            base_reg     <= bus.sp_in;
                            kind_rti_reg <= 1'b1;
                            state_reg    <= POP_F;
                        end else if (bus.start_ret) begin
                            base_reg     <= bus.sp_in;
                            kind_rti_reg <= 1'b0;
                            state_reg    <= POP_LO;
                        end
                    end
                    POP_F: begin
                        state_reg <= POP_LO;
                    end
                    POP_LO: begin
                        if (kind_rti_reg) begin
                            flags_reg <= bus.mem_rdata;
                        end
                        state_reg <= POP_HI;
                    end
                    POP_HI: begin
                        lo_reg    <= bus.mem_rdata;
                        state_reg <= COMMIT;
                    end
                    COMMIT: begin
                        state_reg <= IDLE;
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_stack_pop_sequencer.sv
// Bench for stack_pop_sequencer: directed frames plus random RET/RTI traffic
// checked against a frame-level model of the stack pop protocol.
module tb_stack_pop_sequencer;

    localparam int DW = 16;
    localparam int AW = 11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    stack_pop_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    stack_pop_sequencer #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Stack memory: one-cycle registered read.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];
    end

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        int          load_cyc;
        int          n_pc;
        int          n_fl;
        int          n_sp;
        logic [31:0] pc;
        logic [15:0] fl;
        logic [AW-1:0] sp;
        logic [15:0] stall_bits;
        logic [15:0] rd_bits;
        logic [31:0] last_pc;
    } obs_t;

    logic [AW-1:0] rd_q[$];
    logic [AW-1:0] exp_q[$];

    // Frame model: saved words sit at sp+1 upward (flags first for RTI, then PC lo, PC hi).
    function automatic void model(input bit rti, input logic [AW-1:0] sp,
                                  output logic [31:0] pc, output logic [15:0] fl,
                                  output logic [AW-1:0] sp_new, output int lat);
        logic [AW-1:0] a_lo;
        logic [AW-1:0] a_hi;
        exp_q.delete();
        fl = '0;
        if (rti) begin
            exp_q.push_back(sp + AW'(1));
            fl     = mem[sp + AW'(1)];
            a_lo   = sp + AW'(2);
            a_hi   = sp + AW'(3);
            sp_new = sp + AW'(3);
            lat    = 4;
        end else begin
            a_lo   = sp + AW'(1);
            a_hi   = sp + AW'(2);
            sp_new = sp + AW'(2);
            lat    = 3;
        end
        exp_q.push_back(a_lo);
        exp_q.push_back(a_hi);
        pc = {mem[a_hi], mem[a_lo]};
    endfunction

    // Drives one request in cycle 0 and records what the DUT does for cycles 0..ncyc.
    task automatic run_seq(input bit rti, input bit ret, input logic [AW-1:0] sp,
                           input int flush_cyc, input bit spam, input int ncyc,
                           output obs_t o);
        o = '{default: 0};
        rd_q.delete();
        for (int c = 0; c <= ncyc; c++) begin
            @(posedge clk); #1;
            bus.start_rti = (c == 0) ? rti : 1'b0;
            bus.start_ret = (c == 0) ? ret : (spam && c >= 1 && c <= 2);
            bus.sp_in     = (c == 0) ? sp : AW'($urandom);
            bus.flush     = (c == flush_cyc);
            @(negedge clk);
            if (bus.stall) o.stall_bits[c] = 1'b1;
            if (bus.mem_rd) begin
                o.rd_bits[c] = 1'b1;
                rd_q.push_back(bus.mem_addr);
            end
            if (bus.pc_load) begin
                o.n_pc++;
                o.load_cyc = c;
                o.pc = bus.pc_out;
            end
            if (bus.flags_load) begin
                o.n_fl++;
                o.fl = bus.flags_out;
            end
            if (bus.sp_we) begin
                o.n_sp++;
                o.sp = bus.sp_out;
            end
            o.last_pc = bus.pc_out;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({bus.mem_rd, bus.stall, bus.pc_load, bus.flags_load, bus.sp_we} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_strobes got %b want 00000",
                     {bus.mem_rd, bus.stall, bus.pc_load, bus.flags_load, bus.sp_we});
        end
        n_vec++;
        if (bus.pc_out !== 32'h0) begin
            n_bad++; $display("FAIL reset_pc_out got %h want 0", bus.pc_out);
        end
        n_vec++;
        if (bus.flags_out !== 16'h0) begin
            n_bad++; $display("FAIL reset_flags_out got %h want 0", bus.flags_out);
        end
        n_vec++;
        if (bus.sp_out !== 11'h0 || bus.mem_addr !== 11'h0) begin
            n_bad++; $display("FAIL reset_sp_addr got sp=%h addr=%h want 0/0", bus.sp_out, bus.mem_addr);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        $display("reset: checked idle outputs");
    endtask

    task automatic test_ret();
        obs_t o;
        mem[11'h101] = 16'hBEEF;
        mem[11'h102] = 16'h1234;
        run_seq(1'b0, 1'b1, 11'h100, -1, 1'b0, 5, o);
        n_vec++;
        if (rd_q.size() != 2 || rd_q[0] !== 11'h101 || rd_q[1] !== 11'h102) begin
            n_bad++; $display("FAIL ret_reads got n=%0d %h %h want 2 101 102", rd_q.size(), rd_q[0], rd_q[1]);
        end
        n_vec++;
        if (o.n_pc != 1 || o.load_cyc != 3 || o.pc !== 32'h1234BEEF) begin
            n_bad++; $display("FAIL ret_pc got n=%0d cyc=%0d pc=%h want 1 3 1234beef", o.n_pc, o.load_cyc, o.pc);
        end
        n_vec++;
        if (o.n_sp != 1 || o.sp !== 11'h102 || o.n_fl != 0) begin
            n_bad++; $display("FAIL ret_sp got nsp=%0d sp=%h nfl=%0d want 1 102 0", o.n_sp, o.sp, o.n_fl);
        end
        n_vec++;
        if (o.stall_bits !== 16'h0007 || o.rd_bits !== 16'h0006) begin
            n_bad++; $display("FAIL ret_timing got stall=%h rd=%h want 0007 0006", o.stall_bits, o.rd_bits);
        end
        n_vec++;
        if (o.last_pc !== 32'h1234BEEF) begin
            n_bad++; $display("FAIL ret_hold got pc=%h want 1234beef", o.last_pc);
        end
        $display("ret: sp=100 pc=%h sp_out=%h", o.pc, o.sp);
    endtask

    task automatic test_rti();
        obs_t o;
        mem[11'h201] = 16'h0005;
        mem[11'h202] = 16'h00AA;
        mem[11'h203] = 16'h0001;
        run_seq(1'b1, 1'b0, 11'h200, -1, 1'b0, 5, o);
        n_vec++;
        if (rd_q.size() != 3 || rd_q[0] !== 11'h201 || rd_q[1] !== 11'h202 || rd_q[2] !== 11'h203) begin
            n_bad++; $display("FAIL rti_reads got n=%0d %h %h %h", rd_q.size(), rd_q[0], rd_q[1], rd_q[2]);
        end
        n_vec++;
        if (o.n_pc != 1 || o.load_cyc != 4 || o.pc !== 32'h000100AA) begin
            n_bad++; $display("FAIL rti_pc got n=%0d cyc=%0d pc=%h want 1 4 000100aa", o.n_pc, o.load_cyc, o.pc);
        end
        n_vec++;
        if (o.n_fl != 1 || o.fl !== 16'h0005) begin
            n_bad++; $display("FAIL rti_flags got n=%0d fl=%h want 1 0005", o.n_fl, o.fl);
        end
        n_vec++;
        if (o.n_sp != 1 || o.sp !== 11'h203 || o.stall_bits !== 16'h000F) begin
            n_bad++; $display("FAIL rti_sp got sp=%h stall=%h want 203 000f", o.sp, o.stall_bits);
        end
        n_vec++;
        if (bus.flags_out !== 16'h0005) begin
            n_bad++; $display("FAIL rti_flags_hold got %h want 0005", bus.flags_out);
        end
        $display("rti: sp=200 pc=%h flags=%h sp_out=%h", o.pc, o.fl, o.sp);
    endtask

    task automatic test_both_spam();
        obs_t o;
        logic [31:0] e_pc;
        logic [15:0] e_fl;
        logic [AW-1:0] e_sp;
        int lat;
        model(1'b1, 11'h345, e_pc, e_fl, e_sp, lat);
        run_seq(1'b1, 1'b1, 11'h345, -1, 1'b1, 7, o);
        n_vec++;
        if (rd_q.size() != 3 || o.n_pc != 1 || o.load_cyc != lat) begin
            n_bad++; $display("FAIL both_seq got reads=%0d npc=%0d cyc=%0d want 3 1 %0d",
                              rd_q.size(), o.n_pc, o.load_cyc, lat);
        end
        n_vec++;
        if (o.pc !== e_pc || o.fl !== e_fl || o.sp !== e_sp) begin
            n_bad++; $display("FAIL both_vals got %h %h %h want %h %h %h", o.pc, o.fl, o.sp, e_pc, e_fl, e_sp);
        end
        $display("both+spam: pc=%h loads=%0d", o.pc, o.n_pc);
    endtask

    task automatic test_wrap();
        obs_t o;
        mem[11'h7FF] = 16'hA5A5;
        mem[11'h000] = 16'h5A5A;
        run_seq(1'b0, 1'b1, 11'h7FE, -1, 1'b0, 4, o);
        n_vec++;
        if (rd_q.size() != 2 || rd_q[0] !== 11'h7FF || rd_q[1] !== 11'h000) begin
            n_bad++; $display("FAIL wrap_reads got n=%0d %h %h want 7ff 000", rd_q.size(), rd_q[0], rd_q[1]);
        end
        n_vec++;
        if (o.n_sp != 1 || o.sp !== 11'h000 || o.pc !== 32'h5A5AA5A5) begin
            n_bad++; $display("FAIL wrap_commit got sp=%h pc=%h want 000 5a5aa5a5", o.sp, o.pc);
        end
        $display("wrap: sp=7fe pc=%h sp_out=%h", o.pc, o.sp);
    endtask

    task automatic test_flush();
        obs_t o;
        logic [31:0] prev_pc;
        logic [31:0] e_pc;
        logic [15:0] e_fl;
        logic [AW-1:0] e_sp;
        int lat;
        prev_pc = bus.pc_out;
        run_seq(1'b1, 1'b0, 11'h300, 3, 1'b0, 6, o);
        n_vec++;
        if (o.n_pc != 0 || o.n_fl != 0 || o.n_sp != 0 || o.last_pc !== prev_pc) begin
            n_bad++; $display("FAIL flush_pophi got pulses %0d/%0d/%0d pc=%h want none %h",
                              o.n_pc, o.n_fl, o.n_sp, o.last_pc, prev_pc);
        end
        n_vec++;
        if (o.stall_bits[6:4] !== 3'b0 || o.rd_bits[6:4] !== 3'b0) begin
            n_bad++; $display("FAIL flush_idle got stall=%h rd=%h want upper bits 0", o.stall_bits, o.rd_bits);
        end
        model(1'b0, 11'h310, e_pc, e_fl, e_sp, lat);
        run_seq(1'b0, 1'b1, 11'h310, -1, 1'b0, 4, o);
        n_vec++;
        if (o.n_pc != 1 || o.load_cyc != lat || o.pc !== e_pc || o.sp !== e_sp) begin
            n_bad++; $display("FAIL flush_after_ret got cyc=%0d pc=%h sp=%h want %0d %h %h",
                              o.load_cyc, o.pc, o.sp, lat, e_pc, e_sp);
        end
        prev_pc = e_pc;
        run_seq(1'b0, 1'b1, 11'h320, 3, 1'b0, 5, o);
        n_vec++;
        if (o.n_pc != 0 || o.n_sp != 0 || o.last_pc !== prev_pc) begin
            n_bad++; $display("FAIL flush_commit got npc=%0d nsp=%0d pc=%h want 0 0 %h",
                              o.n_pc, o.n_sp, o.last_pc, prev_pc);
        end
        $display("flush: pop_hi and commit aborts checked");
    endtask

    task automatic test_reset_mid();
        int bad_cycles;
        @(posedge clk); #1;
        bus.start_ret = 1'b1;
        bus.sp_in     = 11'h400;
        bus.flush     = 1'b0;
        @(posedge clk); #1;
        bus.start_ret = 1'b0;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({bus.mem_rd, bus.stall, bus.pc_load, bus.flags_load, bus.sp_we} !== 5'b0 ||
            bus.mem_addr !== 11'h0) begin
            n_bad++; $display("FAIL midrst_strobes got rd=%b stall=%b addr=%h want 0",
                              bus.mem_rd, bus.stall, bus.mem_addr);
        end
        n_vec++;
        if (bus.pc_out !== 32'h0 || bus.flags_out !== 16'h0 || bus.sp_out !== 11'h0) begin
            n_bad++; $display("FAIL midrst_regs got pc=%h fl=%h sp=%h want 0",
                              bus.pc_out, bus.flags_out, bus.sp_out);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        bad_cycles = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (bus.stall || bus.pc_load || bus.flags_load || bus.sp_we || bus.mem_rd) bad_cycles++;
        end
        n_vec++;
        if (bad_cycles != 0) begin
            n_bad++; $display("FAIL midrst_quiet got %0d active cycles want 0", bad_cycles);
        end
        $display("reset_mid: abort during POP_LO checked");
    endtask

    task automatic test_random();
        obs_t o;
        logic [31:0] e_pc;
        logic [15:0] e_fl;
        logic [AW-1:0] e_sp;
        logic [AW-1:0] sp;
        int lat;
        bit rti;
        bit ret;
        bit same;
        for (int it = 0; it < 30; it++) begin
            rti = 1'($urandom_range(0, 1));
            ret = rti ? 1'($urandom_range(0, 1)) : 1'b1;
            sp  = ($urandom_range(0, 3) == 0) ? AW'(11'h7FC + AW'($urandom_range(0, 3))) : AW'($urandom);
            model(rti, sp, e_pc, e_fl, e_sp, lat);
            run_seq(rti, ret, sp, -1, 1'($urandom_range(0, 1)), lat + $urandom_range(0, 2), o);
            n_vec++;
            if (o.n_pc != 1 || o.load_cyc != lat) begin
                n_bad++; $display("FAIL rnd_latency it=%0d got n=%0d cyc=%0d want 1 %0d", it, o.n_pc, o.load_cyc, lat);
            end
            n_vec++;
            if (o.pc !== e_pc) begin
                n_bad++; $display("FAIL rnd_pc it=%0d got %h want %h", it, o.pc, e_pc);
            end
            n_vec++;
            if (o.n_sp != 1 || o.sp !== e_sp) begin
                n_bad++; $display("FAIL rnd_sp it=%0d got n=%0d sp=%h want 1 %h", it, o.n_sp, o.sp, e_sp);
            end
            n_vec++;
            if (o.n_fl != int'(rti) || (rti && o.fl !== e_fl)) begin
                n_bad++; $display("FAIL rnd_flags it=%0d got n=%0d fl=%h want %0d %h", it, o.n_fl, o.fl, rti, e_fl);
            end
            same = (rd_q.size() == exp_q.size());
            foreach (exp_q[i]) begin
                if (i < rd_q.size() && rd_q[i] !== exp_q[i]) same = 1'b0;
            end
            n_vec++;
            if (!same) begin
                n_bad++; $display("FAIL rnd_reads it=%0d got n=%0d first=%h want n=%0d first=%h",
                                  it, rd_q.size(), rd_q[0], exp_q.size(), exp_q[0]);
            end
            n_vec++;
            if (o.stall_bits !== 16'((1 << lat) - 1)) begin
                n_bad++; $display("FAIL rnd_stall it=%0d got %h want %h", it, o.stall_bits, 16'((1 << lat) - 1));
            end
            $display("rnd %0d: %s sp=%h pc=%h sp_out=%h", it, rti ? "RTI" : "RET", sp, o.pc, o.sp);
        end
    endtask

    initial begin
        bus.start_ret = 1'b0;
        bus.start_rti = 1'b0;
        bus.flush     = 1'b0;
        bus.sp_in     = '0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
        test_reset();
        test_ret();
        test_rti();
        test_both_spam();
        test_wrap();
        test_flush();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
